// File: rtl/cba_ro_pkg.sv
// cba_ro_pkg: word types, FSM states and word-width helper shared by the CBA column readout.
package cba_ro_pkg;
   localparam logic [1:0] HIT = 2'd0;
   localparam logic [1:0] HDR = 2'd1;
   localparam logic [1:0] TRL = 2'd2;
   localparam logic [1:0] OVF = 2'd3;
   typedef enum logic [2:0] {
      ST_IDLE, ST_HDR, ST_SETTLE, ST_CHECK, ST_WAIT, ST_TRL
   } state_t;
   function automatic int word_w(input int row_bits, input int data_bits);
      return 2 + row_bits + data_bits;
   endfunction
endpackage

// File: rtl/cba_column_readout_ctrl_if.sv
// cba_column_readout_ctrl_if: request, column and output-word signals of the column readout.
interface cba_column_readout_ctrl_if #(
   parameter int DATA_BITS    = 16,
   parameter int ROW_BITS     = 8,
   parameter int TRIG_ID_BITS = 5
);
   localparam int WW = cba_ro_pkg::word_w(ROW_BITS, DATA_BITS);
   logic                    ReqValid;
   logic [TRIG_ID_BITS-1:0] ReqId;
   logic                    ReqReady;
   logic [TRIG_ID_BITS-1:0] TrigIdReq;
   logic                    Read;
   logic                    ColTok;
   logic [ROW_BITS-1:0]     ColRow;
   logic [DATA_BITS-1:0]    ColData;
   logic                    OutValid;
   logic [WW-1:0]           OutWord;
   logic                    OutReady;
   logic                    Busy;
   modport master (
      input  ReqValid, ReqId, ColTok, ColRow, ColData, OutReady,
      output ReqReady, TrigIdReq, Read, OutValid, OutWord, Busy
   );
   modport slave (
      output ReqValid, ReqId, ColTok, ColRow, ColData, OutReady,
      input  ReqReady, TrigIdReq, Read, OutValid, OutWord, Busy
   );
endinterface

// File: rtl/cba_ro_fifo.sv
// cba_ro_fifo: synchronous output FIFO with full/empty flags and a free-entry count.
module cba_ro_fifo #(
   parameter int WIDTH = 26,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   free
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             wr, rd;
   assign wr      = wr_en && !full;
   assign rd      = rd_en && !empty;
   assign full    = cnt_q == CW'(DEPTH);
   assign empty   = cnt_q == '0;
   assign free    = CW'(DEPTH) - cnt_q;
   assign rd_data = mem_q[rp_q];
   always_comb begin
      wp_d  = wp_q + AW'(wr);
      rp_d  = rp_q + AW'(rd);
      cnt_d = cnt_q + CW'(wr) - CW'(rd);
   end
   always_ff @(posedge clk) begin
      if (wr) mem_q[wp_q] <= wr_data;
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/cba_column_readout_ctrl.sv
// cba_column_readout_ctrl: end-of-column token-chain initiator framing hits as header/hits/trailer words.
// Optional hit limit with overflow trailer enabled by defining CBA_RO_TIMEOUT_EN.
module cba_column_readout_ctrl
   import cba_ro_pkg::*;
#(
   parameter int DATA_BITS    = 16,
   parameter int ROW_BITS     = 8,
   parameter int TRIG_ID_BITS = 5,
   parameter int FIFO_DEPTH   = 8,
   parameter int SETTLE_CYC   = 2,
   parameter int READ_LAT     = 1,
   parameter int MAX_HITS     = 64
) (
   input  logic Clk,
   input  logic Reset,
   cba_column_readout_ctrl_if.master bus
);
   localparam int PW = ROW_BITS + DATA_BITS;
   localparam int WW = word_w(ROW_BITS, DATA_BITS);
   localparam int FW = $clog2(FIFO_DEPTH) + 1;
`ifdef CBA_RO_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif
   state_t                  state_q, state_d;
   logic [TRIG_ID_BITS-1:0] trig_q, trig_d;
   logic [PW-1:0]           cnt_q, cnt_d;
   logic [3:0]              tmr_q, tmr_d;
   logic                    ovf_q, ovf_d;
   logic                    push, full, empty;
   logic [WW-1:0]           push_word;
   logic [FW-1:0]           free;
   cba_ro_fifo #(.WIDTH(WW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(Clk), .rst(Reset), .wr_en(push), .wr_data(push_word),
      .rd_en(bus.OutReady), .rd_data(bus.OutWord),
      .full(full), .empty(empty), .free(free)
   );
   assign bus.OutValid  = !empty;
   assign bus.ReqReady  = (state_q == ST_IDLE) && !Reset;
   assign bus.Busy      = state_q != ST_IDLE;
   assign bus.TrigIdReq = trig_q;
   always_comb begin
      state_d   = state_q;
      trig_d    = trig_q;
      cnt_d     = cnt_q;
      tmr_d     = tmr_q + 4'd1;
      ovf_d     = ovf_q;
      push      = 1'b0;
      push_word = {HIT, bus.ColRow, bus.ColData};
      bus.Read  = 1'b0;
      case (state_q)
         ST_IDLE: if (bus.ReqValid) begin
            trig_d  = bus.ReqId;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = ST_HDR;
         end
         ST_HDR: begin
            push_word = {HDR, PW'(trig_q)};
            push      = !full;
            tmr_d     = '0;
            state_d   = full ? ST_HDR : ST_SETTLE;
         end
         ST_SETTLE: state_d = (tmr_q == 4'(SETTLE_CYC - 1)) ? ST_CHECK : ST_SETTLE;
         // Two free slots keep room for the trailer after this hit.
         ST_CHECK: if (!bus.ColTok) state_d = ST_TRL;
         else if (TMO_EN && cnt_q == PW'(MAX_HITS)) begin
            ovf_d   = 1'b1;
            state_d = ST_TRL;
         end else if (free >= FW'(2)) begin
            bus.Read = 1'b1;
            tmr_d    = '0;
            state_d  = ST_WAIT;
         end
         ST_WAIT: if (tmr_q == 4'(READ_LAT - 1)) begin
            push    = 1'b1;
            cnt_d   = &cnt_q ? cnt_q : cnt_q + 1'b1;
            tmr_d   = '0;
            state_d = ST_SETTLE;
         end
         ST_TRL: begin
            push_word = {ovf_q ? OVF : TRL, cnt_q};
            push      = !full;
            state_d   = full ? ST_TRL : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         trig_q  <= '0;
         cnt_q   <= '0;
         tmr_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         trig_q  <= trig_d;
         cnt_q   <= cnt_d;
         tmr_q   <= tmr_d;
         ovf_q   <= ovf_d;
      end
   end
endmodule
